// File: rtl/spi_reg_bus_master.sv
// Host SPI slave (mode 0, MSB first) bridging 48-bit frames onto the parallel register bus.
// Latency: read cs 1 busClk after the 16th synchronized sclk rise; write strobes 1 busClk after the 48th rise.
// Backpressure: none; the bus cycle is a single fire-and-forget strobe and the host clock is never stalled.
module spi_reg_bus_master #(
   parameter int ADDR_WIDTH  = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  busClk,
   input  logic                  nReset,
   input  logic                  sclk,
   input  logic                  csn,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  misoOe,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [31:0]           dataOut,
   input  logic [31:0]           dataIn,
   output logic                  cs,
   output logic                  wr0,
   output logic                  wr1,
   output logic                  wr2,
   output logic                  wr3,
   output logic                  busy,
   output logic                  frameErr
);

   typedef enum logic [2:0] {IDLE, CMD, DATA, WRITE, WAITCS} state_t;

   logic [SYNC_STAGES-1:0] sclkSync;
   logic [SYNC_STAGES-1:0] csnSync;
   logic [SYNC_STAGES-1:0] mosiSync;
   logic                   sclkPrev;
   logic                   csnPrev;
   logic                   sclkS;
   logic                   csnS;
   logic                   mosiS;
   logic                   sclkRise;
   logic                   sclkFall;
   logic                   csnFall;

   state_t                 state;
   logic [5:0]             bitCnt;
   logic [31:0]            rxShift;
   logic [31:0]            txShift;
   logic [3:0]             byteEn;
   logic                   rw;

   assign sclkS    = sclkSync[SYNC_STAGES-1];
   assign csnS     = csnSync[SYNC_STAGES-1];
   assign mosiS    = mosiSync[SYNC_STAGES-1];
   assign sclkRise = sclkS & ~sclkPrev;
   assign sclkFall = ~sclkS & sclkPrev;
   assign csnFall  = ~csnS & csnPrev;

   // Synchronize the host pins into busClk; csn idles high so reset does not fake a falling edge.
   always_ff @(posedge busClk or negedge nReset) begin
      if (!nReset) begin
         sclkSync <= '0;
         csnSync  <= '1;
         mosiSync <= '0;
         sclkPrev <= 1'b0;
         csnPrev  <= 1'b1;
      end else begin
         sclkSync[0] <= sclk;
         csnSync[0]  <= csn;
         mosiSync[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclkSync[i] <= sclkSync[i-1];
            csnSync[i]  <= csnSync[i-1];
            mosiSync[i] <= mosiSync[i-1];
         end
         sclkPrev <= sclkS;
         csnPrev  <= csnS;
      end
   end

   // Frame FSM: shift command and data, issue exactly one bus strobe per completed frame.
   always_ff @(posedge busClk or negedge nReset) begin
      if (!nReset) begin
         state    <= IDLE;
         bitCnt   <= '0;
         rxShift  <= '0;
         txShift  <= '0;
         byteEn   <= '0;
         rw       <= 1'b0;
         addr     <= '0;
         dataOut  <= '0;
         cs       <= 1'b0;
         {wr3, wr2, wr1, wr0} <= 4'b0000;
         miso     <= 1'b0;
         misoOe   <= 1'b0;
         busy     <= 1'b0;
         frameErr <= 1'b0;
      end else begin
         cs                   <= 1'b0;
         {wr3, wr2, wr1, wr0} <= 4'b0000;
         misoOe               <= ~csnS;
         case (state)
            IDLE: begin
               miso <= 1'b0;
               if (csnFall) begin
                  state  <= CMD;
                  bitCnt <= '0;
                  busy   <= 1'b1;
               end
            end
            CMD: begin
               if (csnS) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  frameErr <= 1'b1;
               end else if (sclkRise) begin
                  rxShift <= {rxShift[30:0], mosiS};
                  bitCnt  <= bitCnt + 6'd1;
                  if (bitCnt == 6'd15) begin
                     // rxShift[k-1] holds command bit k; mosiS is command bit 0
                     rw     <= rxShift[14];
                     byteEn <= rxShift[10:7];
                     addr   <= {rxShift[ADDR_WIDTH-2:0], mosiS};
                     cs     <= rxShift[14];
                     state  <= DATA;
                  end
               end
            end
            DATA: begin
               if (csnS) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  miso     <= 1'b0;
                  frameErr <= 1'b1;
               end else begin
                  // Read data is taken while the read cs is on the bus, then shifted out on sclk falls
                  if (cs && rw) begin
                     txShift <= dataIn;
                  end else if (sclkFall && rw) begin
                     miso    <= txShift[31];
                     txShift <= {txShift[30:0], 1'b0};
                  end
                  if (sclkRise) begin
                     rxShift <= {rxShift[30:0], mosiS};
                     bitCnt  <= bitCnt + 6'd1;
                     if (bitCnt == 6'd47) begin
                        frameErr <= 1'b0;
                        if (rw) begin
                           miso  <= 1'b0;
                           state <= WAITCS;
                        end else begin
                           dataOut              <= {rxShift[30:0], mosiS};
                           cs                   <= 1'b1;
                           {wr3, wr2, wr1, wr0} <= byteEn;
                           state                <= WRITE;
                        end
                     end
                  end
               end
            end
            WRITE: begin
               state <= WAITCS;
            end
            WAITCS: begin
               miso <= 1'b0;
               if (csnS) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_reg_bus_master.sv
// Directed bench for spi_reg_bus_master: write, read, abort, reset and back-to-back frames.
// Host SPI pins change on busClk falling edges; sclk half period is HALF busClk cycles.
// Bus strobes are logged by a monitor on the falling edge of busClk.
module tb_spi_reg_bus_master;

   localparam int HALF = 4;

   logic        busClk = 1'b0;
   logic        nReset = 1'b0;
   logic        sclk   = 1'b0;
   logic        csn    = 1'b1;
   logic        mosi   = 1'b0;
   logic        miso;
   logic        misoOe;
   logic [5:0]  addr;
   logic [31:0] dataOut;
   logic [31:0] dataIn = 32'h0;
   logic        cs;
   logic        wr0, wr1, wr2, wr3;
   logic        busy;
   logic        frameErr;

   int errors = 0;
   int checks = 0;

   logic [5:0]  logAddr[$];
   logic [31:0] logData[$];
   logic [3:0]  logWr[$];
   int          widePulse = 0;
   int          strayWr   = 0;
   logic        prevCs    = 1'b0;

   spi_reg_bus_master #(.ADDR_WIDTH(6), .SYNC_STAGES(2)) dut (
      .busClk(busClk), .nReset(nReset), .sclk(sclk), .csn(csn), .mosi(mosi),
      .miso(miso), .misoOe(misoOe), .addr(addr), .dataOut(dataOut), .dataIn(dataIn),
      .cs(cs), .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3),
      .busy(busy), .frameErr(frameErr)
   );

   always #5 busClk = ~busClk;

   // Log every bus strobe, and note strobes that last more than one cycle or wr without cs.
   always @(negedge busClk) begin
      if (cs) begin
         logAddr.push_back(addr);
         logData.push_back(dataOut);
         logWr.push_back({wr3, wr2, wr1, wr0});
         if (prevCs) widePulse++;
      end
      if ((wr0 | wr1 | wr2 | wr3) && !cs) strayWr++;
      prevCs = cs;
   end

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
      logWr.delete();
   endtask

   task automatic frame(input logic [15:0] cmd, input logic [31:0] data, input int nbits,
                        input bit endFrame, input int gap, output logic [31:0] rdata);
      logic [47:0] word;
      word  = {cmd, data};
      rdata = 32'h0;
      @(negedge busClk);
      csn = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = word[47-i];
         repeat (HALF) @(negedge busClk);
         if (i >= 16) rdata = {rdata[30:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge busClk);
         sclk = 1'b0;
      end
      if (endFrame) begin
         repeat (HALF) @(negedge busClk);
         csn  = 1'b1;
         mosi = 1'b0;
         repeat (gap) @(negedge busClk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge busClk);
      checks++;
      if ({cs, wr3, wr2, wr1, wr0, miso, misoOe, busy, frameErr} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000000", {cs, wr3, wr2, wr1, wr0, miso, misoOe, busy, frameErr});
      end
      checks++;
      if (addr !== 6'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", addr); end
      checks++;
      if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", dataOut); end
      nReset = 1'b1;
      repeat (4) @(negedge busClk);
   endtask

   task automatic test_write_all();
      logic [31:0] rd;
      clearLog();
      frame(16'h0F05, 32'hDEADBEEF, 48, 1'b1, 8, rd);
      checks++;
      if (logAddr.size() !== 1) begin errors++; $display("FAIL wr_all_count: got %0d expected 1", logAddr.size()); end
      else begin
         checks++;
         if (logAddr[0] !== 6'h05) begin errors++; $display("FAIL wr_all_addr: got %h expected 05", logAddr[0]); end
         checks++;
         if (logData[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_all_data: got %h expected deadbeef", logData[0]); end
         checks++;
         if (logWr[0] !== 4'b1111) begin errors++; $display("FAIL wr_all_lanes: got %b expected 1111", logWr[0]); end
      end
      checks++;
      if (frameErr !== 1'b0) begin errors++; $display("FAIL wr_all_ferr: got %b expected 0", frameErr); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL wr_all_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write_partial();
      logic [31:0] rd;
      clearLog();
      frame(16'h0C07, 32'h12345678, 48, 1'b1, 8, rd);
      checks++;
      if (logAddr.size() !== 1) begin errors++; $display("FAIL wr_part_count: got %0d expected 1", logAddr.size()); end
      else begin
         checks++;
         if (logAddr[0] !== 6'h07) begin errors++; $display("FAIL wr_part_addr: got %h expected 07", logAddr[0]); end
         checks++;
         if (logData[0] !== 32'h12345678) begin errors++; $display("FAIL wr_part_data: got %h expected 12345678", logData[0]); end
         checks++;
         if (logWr[0] !== 4'b1100) begin errors++; $display("FAIL wr_part_lanes: got %b expected 1100", logWr[0]); end
      end
   endtask

   task automatic test_read();
      logic [31:0] rd;
      clearLog();
      dataIn = 32'hA5A50F0F;
      frame(16'h8003, 32'hFFFF0000, 48, 1'b1, 8, rd);
      dataIn = 32'h0;
      checks++;
      if (rd !== 32'hA5A50F0F) begin errors++; $display("FAIL rd_miso: got %h expected a5a50f0f", rd); end
      checks++;
      if (logAddr.size() !== 1) begin errors++; $display("FAIL rd_count: got %0d expected 1", logAddr.size()); end
      else begin
         checks++;
         if (logAddr[0] !== 6'h03) begin errors++; $display("FAIL rd_addr: got %h expected 03", logAddr[0]); end
         checks++;
         if (logWr[0] !== 4'b0000) begin errors++; $display("FAIL rd_lanes: got %b expected 0000", logWr[0]); end
      end
      checks++;
      if ({misoOe, miso} !== 2'b00) begin errors++; $display("FAIL rd_idle_pins: got %b expected 00", {misoOe, miso}); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      clearLog();
      frame(16'h0F09, 32'hCAFEBABE, 30, 1'b1, 8, rd);
      checks++;
      if (logAddr.size() !== 0) begin errors++; $display("FAIL abort_strobe: got %0d expected 0", logAddr.size()); end
      checks++;
      if (frameErr !== 1'b1) begin errors++; $display("FAIL abort_ferr: got %b expected 1", frameErr); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      frame(16'h0F0A, 32'h00000001, 48, 1'b1, 8, rd);
      checks++;
      if (frameErr !== 1'b0) begin errors++; $display("FAIL abort_clear: got %b expected 0", frameErr); end
      checks++;
      if (logAddr.size() !== 1 || logAddr[0] !== 6'h0A) begin
         errors++;
         $display("FAIL abort_next: got count %0d expected 1 at addr 0a", logAddr.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      clearLog();
      frame(16'h0F3C, 32'h87654321, 20, 1'b0, 0, rd);
      checks++;
      if ({busy, misoOe, addr} !== {2'b11, 6'h3C}) begin
         errors++;
         $display("FAIL midrst_before: got %b %h expected 11 3c", {busy, misoOe}, addr);
      end
      nReset = 1'b0;
      #2;
      checks++;
      if ({cs, wr3, wr2, wr1, wr0, miso, misoOe, busy, frameErr} !== 9'b0 || addr !== 6'h00) begin
         errors++;
         $display("FAIL midrst_async: got %b addr %h expected 0", {cs, wr3, wr2, wr1, wr0, miso, misoOe, busy, frameErr}, addr);
      end
      csn = 1'b1;
      repeat (4) @(negedge busClk);
      nReset = 1'b1;
      repeat (6) @(negedge busClk);
      checks++;
      if (logAddr.size() !== 0) begin errors++; $display("FAIL midrst_strobe: got %0d expected 0", logAddr.size()); end
      frame(16'h0F01, 32'hCAFEF00D, 48, 1'b1, 8, rd);
      checks++;
      if (logAddr.size() !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", logAddr.size()); end
      else begin
         checks++;
         if ({logAddr[0], logData[0], logWr[0]} !== {6'h01, 32'hCAFEF00D, 4'b1111}) begin
            errors++;
            $display("FAIL midrst_next: got %h %h %b expected 01 cafef00d 1111", logAddr[0], logData[0], logWr[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      clearLog();
      frame(16'h0F11, 32'h11111111, 48, 1'b1, 2, rd);
      frame(16'h0012, 32'h22220000, 48, 1'b1, 8, rd);
      checks++;
      if (logAddr.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", logAddr.size()); end
      else begin
         checks++;
         if ({logAddr[0], logData[0], logWr[0]} !== {6'h11, 32'h11111111, 4'b1111}) begin
            errors++;
            $display("FAIL b2b_first: got %h %h %b expected 11 11111111 1111", logAddr[0], logData[0], logWr[0]);
         end
         checks++;
         if ({logAddr[1], logData[1], logWr[1]} !== {6'h12, 32'h22220000, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_second: got %h %h %b expected 12 22220000 0000", logAddr[1], logData[1], logWr[1]);
         end
      end
      checks++;
      if (addr !== 6'h12 || dataOut !== 32'h22220000) begin
         errors++;
         $display("FAIL b2b_hold: got %h %h expected 12 22220000", addr, dataOut);
      end
   endtask

   task automatic test_strobe_shape();
      checks++;
      if (widePulse !== 0) begin errors++; $display("FAIL cs_width: got %0d wide pulses expected 0", widePulse); end
      checks++;
      if (strayWr !== 0) begin errors++; $display("FAIL stray_wr: got %0d expected 0", strayWr); end
   endtask

   initial begin
      test_reset();
      test_write_all();
      test_write_partial();
      test_read();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_strobe_shape();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
